// File: rtl/mem_req_master.sv
// Load/store request master: turns one MEM-stage access into a single bus transaction
// and returns a one-cycle completion pulse with lane-aligned, extended load data.
module mem_req_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid_i,
    input  logic        mem_req_write_i,
    input  logic [63:0] mem_req_addr_i,
    input  logic [1:0]  mem_req_size_i,
    input  logic        mem_req_unsigned_i,
    input  logic [63:0] mem_req_wdata_i,
    input  logic        flush_i,
    output logic        mem_stall_o,
    output logic        mem_rsp_valid_o,
    output logic [63:0] mem_rsp_rdata_o,
    output logic        mem_rsp_err_o,
    output logic        bus_valid_o,
    output logic        bus_req_o,
    output logic [63:0] bus_addr_o,
    output logic [1:0]  bus_size_o,
    output logic [63:0] bus_data_write_o,
    input  logic        bus_ready_i,
    input  logic [63:0] bus_data_read_i,
    input  logic [1:0]  bus_resp_i,
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW     = (CW_RAW > 9) ? CW_RAW : 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Handshake: the bus request is presented while bus_valid_o is high and all
    // request fields stay stable until bus_ready_i is sampled high on a rising edge.
    state_t         state_q, state_d;
    logic [63:0]    addr_q, addr_d;
    logic [1:0]     size_q, size_d;
    logic           write_q, write_d;
    logic           uns_q, uns_d;
    logic [63:0]    wdata_q, wdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           drop_q, drop_d;
    logic [63:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic           misaligned;
    logic [63:0]    rd_shifted;
    logic [63:0]    rd_ext;
    logic [CW-1:0]  cnt_inc;

    always_comb begin
        misaligned = 1'b0;
        case (mem_req_size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_req_addr_i[0];
            2'b10:   misaligned = |mem_req_addr_i[1:0];
            default: misaligned = |mem_req_addr_i[2:0];
        endcase
    end

    always_comb begin
        rd_shifted = bus_data_read_i >> {addr_q[2:0], 3'b000};
        rd_ext     = rd_shifted;
        case (size_q)
            2'b00:   rd_ext = uns_q ? {56'd0, rd_shifted[7:0]}  : {{56{rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   rd_ext = uns_q ? {48'd0, rd_shifted[15:0]} : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            2'b10:   rd_ext = uns_q ? {32'd0, rd_shifted[31:0]} : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req_valid_i && !flush_i) begin
                    drop_d = 1'b0;
                    if (misaligned) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = S_WAIT;
                        addr_d  = mem_req_addr_i;
                        size_d  = mem_req_size_i;
                        write_d = mem_req_write_i;
                        uns_d   = mem_req_unsigned_i;
                        wdata_d = mem_req_wdata_i << {mem_req_addr_i[2:0], 3'b000};
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                // A ready in the same cycle as the timeout still completes normally.
                if (bus_ready_i) begin
                    state_d = S_RESP;
                    rdata_d = write_q ? 64'd0 : rd_ext;
                    err_d   = (bus_resp_i != 2'b00);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                        state_d = S_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Stall is gated by reset so every output reads zero while reset is held.
    assign mem_stall_o      = rst && (((state_q == S_IDLE) && mem_req_valid_i) || (state_q == S_WAIT));
    assign mem_rsp_valid_o  = (state_q == S_RESP) && !drop_q && !flush_i;
    assign mem_rsp_rdata_o  = (state_q == S_RESP) ? rdata_q : 64'd0;
    assign mem_rsp_err_o    = (state_q == S_RESP) && err_q;
    assign bus_valid_o      = (state_q == S_WAIT);
    assign bus_req_o        = write_q;
    assign bus_addr_o       = addr_q;
    assign bus_size_o       = size_q;
    assign bus_data_write_o = wdata_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master: loads, stores, misalignment, timeout, flush and reset cases.
module tb_mem_req_master;

    logic        clk;
    logic        rst;
    logic        mem_req_valid_i;
    logic        mem_req_write_i;
    logic [63:0] mem_req_addr_i;
    logic [1:0]  mem_req_size_i;
    logic        mem_req_unsigned_i;
    logic [63:0] mem_req_wdata_i;
    logic        flush_i;
    logic        mem_stall_o;
    logic        mem_rsp_valid_o;
    logic [63:0] mem_rsp_rdata_o;
    logic        mem_rsp_err_o;
    logic        bus_valid_o;
    logic        bus_req_o;
    logic [63:0] bus_addr_o;
    logic [1:0]  bus_size_o;
    logic [63:0] bus_data_write_o;
    logic        bus_ready_i;
    logic [63:0] bus_data_read_i;
    logic [1:0]  bus_resp_i;
    logic [1:0]  dbg_state_o;

    int n_vec;
    int n_err;

    mem_req_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_req_valid_i    (mem_req_valid_i),
        .mem_req_write_i    (mem_req_write_i),
        .mem_req_addr_i     (mem_req_addr_i),
        .mem_req_size_i     (mem_req_size_i),
        .mem_req_unsigned_i (mem_req_unsigned_i),
        .mem_req_wdata_i    (mem_req_wdata_i),
        .flush_i            (flush_i),
        .mem_stall_o        (mem_stall_o),
        .mem_rsp_valid_o    (mem_rsp_valid_o),
        .mem_rsp_rdata_o    (mem_rsp_rdata_o),
        .mem_rsp_err_o      (mem_rsp_err_o),
        .bus_valid_o        (bus_valid_o),
        .bus_req_o          (bus_req_o),
        .bus_addr_o         (bus_addr_o),
        .bus_size_o         (bus_size_o),
        .bus_data_write_o   (bus_data_write_o),
        .bus_ready_i        (bus_ready_i),
        .bus_data_read_i    (bus_data_read_i),
        .bus_resp_i         (bus_resp_i),
        .dbg_state_o        (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata);
        mem_req_valid_i    = 1'b1;
        mem_req_write_i    = wr;
        mem_req_addr_i     = addr;
        mem_req_size_i     = size;
        mem_req_unsigned_i = uns;
        mem_req_wdata_i    = wdata;
    endtask

    task automatic idle_inputs();
        mem_req_valid_i = 1'b0;
        bus_ready_i     = 1'b0;
        bus_resp_i      = 2'b00;
        flush_i         = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst                = 1'b0;
        mem_req_valid_i    = 1'b0;
        mem_req_write_i    = 1'b0;
        mem_req_addr_i     = '0;
        mem_req_size_i     = '0;
        mem_req_unsigned_i = 1'b0;
        mem_req_wdata_i    = '0;
        flush_i            = 1'b0;
        bus_ready_i        = 1'b0;
        bus_data_read_i    = '0;
        bus_resp_i         = '0;

        // Reset state, with a request pending to prove stall stays low under reset
        @(negedge clk);
        mem_req_valid_i = 1'b1;
        @(negedge clk);
        #1;
        check("rst_stall", {63'd0, mem_stall_o}, 64'd0);
        check("rst_bus_valid", {63'd0, bus_valid_o}, 64'd0);
        check("rst_rsp_valid", {63'd0, mem_rsp_valid_o}, 64'd0);
        check("rst_bus_addr", bus_addr_o, 64'd0);
        check("rst_state", {62'd0, dbg_state_o}, 64'd0);
        mem_req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Load word, sign-extended, immediate ready
        issue(1'b0, 64'h0000_0000_0000_0204, 2'b10, 1'b0, 64'd0);
        #1;
        check("lw_stall_idle", {63'd0, mem_stall_o}, 64'd1);
        cycle();
        idle_inputs();
        bus_ready_i     = 1'b1;
        bus_data_read_i = 64'h8000_0001_0000_0000;
        #1;
        check("lw_bus_valid", {63'd0, bus_valid_o}, 64'd1);
        check("lw_bus_req", {63'd0, bus_req_o}, 64'd0);
        check("lw_bus_addr", bus_addr_o, 64'h0000_0000_0000_0204);
        check("lw_bus_size", {62'd0, bus_size_o}, 64'd2);
        check("lw_stall_wait", {63'd0, mem_stall_o}, 64'd1);
        check("lw_no_early_rsp", {63'd0, mem_rsp_valid_o}, 64'd0);
        cycle();
        bus_ready_i = 1'b0;
        #1;
        check("lw_rsp_valid", {63'd0, mem_rsp_valid_o}, 64'd1);
        check("lw_rdata", mem_rsp_rdata_o, 64'hFFFF_FFFF_8000_0001);
        check("lw_err", {63'd0, mem_rsp_err_o}, 64'd0);
        check("lw_bus_valid_drop", {63'd0, bus_valid_o}, 64'd0);
        check("lw_stall_resp", {63'd0, mem_stall_o}, 64'd0);
        cycle();
        check("lw_rsp_one_cycle", {63'd0, mem_rsp_valid_o}, 64'd0);

        // Store byte 0xAB at offset 3, held off for one cycle to test stability
        issue(1'b1, 64'h0000_0000_0000_0003, 2'b00, 1'b0, 64'h0000_0000_0000_00AB);
        cycle();
        idle_inputs();
        #1;
        check("sb_bus_req", {63'd0, bus_req_o}, 64'd1);
        check("sb_wdata", bus_data_write_o, 64'h0000_0000_AB00_0000);
        check("sb_size", {62'd0, bus_size_o}, 64'd0);
        cycle();
        bus_ready_i     = 1'b1;
        bus_data_read_i = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("sb_stable_valid", {63'd0, bus_valid_o}, 64'd1);
        check("sb_stable_wdata", bus_data_write_o, 64'h0000_0000_AB00_0000);
        cycle();
        bus_ready_i = 1'b0;
        #1;
        check("sb_rsp_valid", {63'd0, mem_rsp_valid_o}, 64'd1);
        check("sb_rdata_zero", mem_rsp_rdata_o, 64'd0);
        check("sb_err", {63'd0, mem_rsp_err_o}, 64'd0);
        cycle();

        // Misaligned half: no bus request, error response the next cycle
        issue(1'b0, 64'h0000_0000_0000_0001, 2'b01, 1'b0, 64'd0);
        cycle();
        idle_inputs();
        #1;
        check("mis_bus_valid", {63'd0, bus_valid_o}, 64'd0);
        check("mis_rsp_valid", {63'd0, mem_rsp_valid_o}, 64'd1);
        check("mis_err", {63'd0, mem_rsp_err_o}, 64'd1);
        check("mis_rdata", mem_rsp_rdata_o, 64'd0);
        cycle();

        // Timeout: ready never arrives, bus_valid holds for exactly 4 cycles
        issue(1'b0, 64'h0000_0000_0000_0008, 2'b11, 1'b0, 64'd0);
        cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("to_bus_valid_%0d", i), {63'd0, bus_valid_o}, 64'd1);
            cycle();
        end
        #1;
        check("to_bus_valid_drop", {63'd0, bus_valid_o}, 64'd0);
        check("to_rsp_valid", {63'd0, mem_rsp_valid_o}, 64'd1);
        check("to_err", {63'd0, mem_rsp_err_o}, 64'd1);
        check("to_rdata", mem_rsp_rdata_o, 64'd0);
        cycle();

        // Flush in WAIT: handshake completes on the timeout cycle (ready wins), response dropped
        issue(1'b0, 64'h0000_0000_0000_0010, 2'b10, 1'b1, 64'd0);
        cycle();
        idle_inputs();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        cycle();
        cycle();
        bus_ready_i     = 1'b1;
        bus_data_read_i = 64'h0000_0000_1234_5678;
        #1;
        check("fl_bus_valid_held", {63'd0, bus_valid_o}, 64'd1);
        cycle();
        bus_ready_i = 1'b0;
        #1;
        check("fl_rsp_dropped", {63'd0, mem_rsp_valid_o}, 64'd0);
        check("fl_bus_valid_drop", {63'd0, bus_valid_o}, 64'd0);
        check("fl_state_resp", {62'd0, dbg_state_o}, 64'd2);
        cycle();
        check("fl_state_idle", {62'd0, dbg_state_o}, 64'd0);

        // Signed byte with bus error response
        issue(1'b0, 64'h0000_0000_0000_0005, 2'b00, 1'b0, 64'd0);
        cycle();
        idle_inputs();
        bus_ready_i     = 1'b1;
        bus_resp_i      = 2'b10;
        bus_data_read_i = 64'h0000_FF00_0000_0000;
        cycle();
        idle_inputs();
        #1;
        check("lb_rsp_valid", {63'd0, mem_rsp_valid_o}, 64'd1);
        check("lb_rdata", mem_rsp_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check("lb_err", {63'd0, mem_rsp_err_o}, 64'd1);
        cycle();

        // Unsigned half; flush during RESP masks the pulse
        issue(1'b0, 64'h0000_0000_0000_0006, 2'b01, 1'b1, 64'd0);
        cycle();
        idle_inputs();
        bus_ready_i     = 1'b1;
        bus_data_read_i = 64'hBEEF_0000_0000_0000;
        cycle();
        idle_inputs();
        #1;
        check("lhu_rdata", mem_rsp_rdata_o, 64'h0000_0000_0000_BEEF);
        check("lhu_rsp_valid", {63'd0, mem_rsp_valid_o}, 64'd1);
        flush_i = 1'b1;
        #1;
        check("resp_flush_mask", {63'd0, mem_rsp_valid_o}, 64'd0);
        cycle();
        flush_i = 1'b0;

        // Flush in IDLE blocks acceptance
        issue(1'b0, 64'h0000_0000_0000_0020, 2'b11, 1'b0, 64'd0);
        flush_i = 1'b1;
        cycle();
        idle_inputs();
        #1;
        check("idle_flush_block", {63'd0, bus_valid_o}, 64'd0);
        check("idle_flush_state", {62'd0, dbg_state_o}, 64'd0);

        // Reset mid-WAIT abandons the transaction; first request after release is accepted
        issue(1'b0, 64'h0000_0000_0000_0040, 2'b11, 1'b0, 64'd0);
        cycle();
        idle_inputs();
        #1;
        check("rw_bus_valid", {63'd0, bus_valid_o}, 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rw_bus_valid_async", {63'd0, bus_valid_o}, 64'd0);
        check("rw_addr_async", bus_addr_o, 64'd0);
        bus_ready_i = 1'b1;
        cycle();
        rst = 1'b1;
        bus_ready_i = 1'b0;
        issue(1'b0, 64'h0000_0000_0000_0080, 2'b11, 1'b0, 64'd0);
        #1;
        check("rw_no_rsp", {63'd0, mem_rsp_valid_o}, 64'd0);
        cycle();
        idle_inputs();
        bus_ready_i     = 1'b1;
        bus_data_read_i = 64'h0123_4567_89AB_CDEF;
        #1;
        check("rw_first_accept", {63'd0, bus_valid_o}, 64'd1);
        check("rw_no_rsp_wait", {63'd0, mem_rsp_valid_o}, 64'd0);
        cycle();
        idle_inputs();
        #1;
        check("ld_rdata", mem_rsp_rdata_o, 64'h0123_4567_89AB_CDEF);
        check("ld_rsp_valid", {63'd0, mem_rsp_valid_o}, 64'd1);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
